fp_divide: RTL and testbench

- Sequential signed fixed-point divider: quo = dividend / divisor in the same Q(WIDTH-FRAC_WIDTH).FRAC_WIDTH format as the datapath multiplier.
- Radix-2 restoring long division on magnitudes, one quotient bit per clock; sign applied at the end.
- Saturates and flags results that fall outside the format, and handles divide-by-zero.
- Used by the raycasting math (e.g. reciprocal ray-direction, wall-distance to line-height) where a single-cycle divider will not close timing.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/udiv_core.sv | 79 +++++++
 rtl/fp_divide.sv | 162 ++++++++++++++++
 tb/tb_fp_divide.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared fixed-point helpers: divider FSM state type, saturation limits and magnitude.
package fp_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDivide = 2'd1,
        StDone   = 2'd2
    } fp_div_state_e;

    // Largest positive value of a w-bit signed word, zero-extended to 64 bits.
    function automatic logic [63:0] fp_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative w-bit signed word.
    function automatic logic [63:0] fp_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

    // Magnitude of a w-bit two's-complement value held in the low bits of v.
    // The most negative input maps to 2^(w-1) as an unsigned w-bit result.
    function automatic logic [63:0] fp_abs(input logic [63:0] v, input int unsigned w);
        logic [63:0] mask;
        logic        neg;
        mask = (64'd1 << w) - 64'd1;
        neg  = |(v & (64'd1 << (w - 1)));
        if (neg) begin
            return (~v + 64'd1) & mask;
        end
        return v & mask;
    endfunction

endpackage

// File: rtl/udiv_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per clock, NUM_W iterations.
module udiv_core #(
    parameter int unsigned NUM_W = 24,
    parameter int unsigned DEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic             done_o,
    output logic [NUM_W-1:0] quo_o
);

    localparam int unsigned CNT_W = $clog2(NUM_W + 1);

    // The numerator register doubles as the quotient: bits leave at the top
    // and quotient bits enter at the bottom.
    logic [NUM_W-1:0] num_q, num_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [DEN_W:0]   rem_sh;
    logic [DEN_W:0]   rem_sub;
    logic             take_bit;
    logic             last_iter;

    always_comb begin
        rem_sh    = {rem_q, num_q[NUM_W-1]};
        rem_sub   = rem_sh - {1'b0, den_q};
        take_bit  = (rem_sh >= {1'b0, den_q});
        last_iter = busy_q && (cnt_q == CNT_W'(NUM_W - 1));
    end

    always_comb begin
        num_d  = num_q;
        den_d  = den_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i && !busy_q) begin
            num_d  = num_i;
            den_d  = den_i;
            rem_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            num_d = {num_q[NUM_W-2:0], take_bit};
            rem_d = DEN_W'(take_bit ? rem_sub : rem_sh);
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            num_q  <= '0;
            den_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            num_q  <= num_d;
            den_q  <= den_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // High during the final iteration; quo_o is complete after this edge.
    assign done_o = last_iter;
    assign quo_o  = num_q;

endmodule

// File: rtl/fp_divide.sv
// Sequential signed Qm.f divider with saturation and divide-by-zero handling.
// Define FP_DIVIDE_ROUND_EN for round-half-away-from-zero (one extra iteration).
module fp_divide
    import fp_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FRAC_WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] quo,
    output logic             ovrflw,
    output logic             div_zero
);

    localparam int unsigned N = WIDTH + FRAC_WIDTH;
`ifdef FP_DIVIDE_ROUND_EN
    localparam int unsigned NUM_W = N + 1;
`else
    localparam int unsigned NUM_W = N;
`endif
    localparam int unsigned QW = N + 1;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(fp_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(fp_min(WIDTH));
    localparam logic [QW-1:0]    POS_LIM = QW'(fp_max(WIDTH));
    localparam logic [QW-1:0]    NEG_LIM = QW'(fp_min(WIDTH));

    fp_div_state_e    state_q, state_d;
    logic             sign_q, sign_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             ovf_q, ovf_d;
    logic             div_zero_q, div_zero_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             dvs_zero;
    logic [WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0] abs_dvs;
    logic [NUM_W-1:0] num_load;
    logic             core_done;
    logic [NUM_W-1:0] core_quo;
    logic [QW-1:0]    q_mag;
    logic [WIDTH-1:0] q_lo;
    logic [WIDTH-1:0] quo_sat;
    logic             ovf_sat;

    assign ready_out = (state_q == StIdle);
    assign accept    = valid_in && ready_out;
    assign dvs_zero  = (divisor == '0);
    assign abs_dvd   = WIDTH'(fp_abs(64'(dividend), WIDTH));
    assign abs_dvs   = WIDTH'(fp_abs(64'(divisor), WIDTH));
    assign num_load  = {abs_dvd, {(NUM_W - WIDTH){1'b0}}};

    udiv_core #(
        .NUM_W (NUM_W),
        .DEN_W (WIDTH)
    ) u_udiv_core (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .start_i (accept && !dvs_zero),
        .num_i   (num_load),
        .den_i   (abs_dvs),
        .done_o  (core_done),
        .quo_o   (core_quo)
    );

    // The extra guard bit rounds the magnitude half-up, i.e. away from zero once signed.
`ifdef FP_DIVIDE_ROUND_EN
    assign q_mag = QW'(core_quo[NUM_W-1:1]) + QW'(core_quo[0]);
`else
    assign q_mag = QW'(core_quo);
`endif
    assign q_lo = q_mag[WIDTH-1:0];

    always_comb begin
        quo_sat = sign_q ? (~q_lo + WIDTH'(1)) : q_lo;
        ovf_sat = 1'b0;
        if (!sign_q && (q_mag > POS_LIM)) begin
            quo_sat = MAX_VAL;
            ovf_sat = 1'b1;
        end else if (sign_q && (q_mag > NEG_LIM)) begin
            quo_sat = MIN_VAL;
            ovf_sat = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        dvd_neg_d  = dvd_neg_q;
        dz_d       = dz_q;
        quo_d      = quo_q;
        ovf_d      = ovf_q;
        div_zero_d = div_zero_q;
        valid_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    sign_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    dvd_neg_d = dividend[WIDTH-1];
                    dz_d      = dvs_zero;
                    state_d   = dvs_zero ? StDone : StDivide;
                end
            end
            StDivide: begin
                if (core_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                valid_d = 1'b1;
                state_d = StIdle;
                if (dz_q) begin
                    quo_d      = dvd_neg_q ? MIN_VAL : MAX_VAL;
                    ovf_d      = 1'b1;
                    div_zero_d = 1'b1;
                end else begin
                    quo_d      = quo_sat;
                    ovf_d      = ovf_sat;
                    div_zero_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            sign_q     <= 1'b0;
            dvd_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
            quo_q      <= '0;
            ovf_q      <= 1'b0;
            div_zero_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            dvd_neg_q  <= dvd_neg_d;
            dz_q       <= dz_d;
            quo_q      <= quo_d;
            ovf_q      <= ovf_d;
            div_zero_q <= div_zero_d;
            valid_q    <= valid_d;
        end
    end

    assign valid_out = valid_q;
    assign quo       = quo_q;
    assign ovrflw    = ovf_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_fp_divide.sv
// Scoreboard bench for fp_divide (Q8.8): directed vectors, handshake and mid-op reset.
module tb_fp_divide;

`ifdef FP_DIVIDE_ROUND_EN
    localparam int LAT = 26;
`else
    localparam int LAT = 25;
`endif

    logic        clk;
    logic        rst_in;
    logic        valid_in;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        ready_out;
    logic        valid_out;
    logic [15:0] quo;
    logic        ovrflw;
    logic        div_zero;

    typedef struct {
        logic [15:0] q;
        logic        ovf;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    fp_divide #(
        .WIDTH      (16),
        .FRAC_WIDTH (8)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst_in),
        .valid_in  (valid_in),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .quo       (quo),
        .ovrflw    (ovrflw),
        .div_zero  (div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the following negedge with valid_in low.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                         input logic ovf, input logic dz, input int lat);
        int n;
        n = 0;
        while (!ready_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_out) begin
            check("ready_wait", 32'(ready_out), 32'd1);
            return;
        end
        valid_in = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back('{q: q, ovf: ovf, dz: dz, acc: cyc + 1, lat: lat});
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // Monitor: pops one expectation per valid_out pulse.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_in && valid_out) begin
            if (sb.size() == 0) begin
                check("stray_valid", 32'(valid_out), 32'd0);
            end else begin
                e = sb.pop_front();
                check("quo", 32'(quo), 32'(e.q));
                check("ovrflw", 32'(ovrflw), 32'(e.ovf));
                check("div_zero", 32'(div_zero), 32'(e.dz));
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc1;
        int n;
        rst_in   = 1'b1;
        valid_in = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_quo", 32'(quo), 32'd0);
        check("rst_ovrflw", 32'(ovrflw), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        rst_in = 1'b0;
        @(negedge clk);

        do_op(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, LAT);
        do_op(16'hFF00, 16'h0400, 16'hFFC0, 1'b0, 1'b0, LAT);
`ifdef FP_DIVIDE_ROUND_EN
        do_op(16'h0200, 16'h0300, 16'h00AB, 1'b0, 1'b0, LAT);
        do_op(16'hFE00, 16'h0300, 16'hFF55, 1'b0, 1'b0, LAT);
        do_op(16'hFFFF, 16'h0200, 16'hFFFF, 1'b0, 1'b0, LAT);
`else
        do_op(16'h0200, 16'h0300, 16'h00AA, 1'b0, 1'b0, LAT);
        do_op(16'hFE00, 16'h0300, 16'hFF56, 1'b0, 1'b0, LAT);
        do_op(16'hFFFF, 16'h0200, 16'h0000, 1'b0, 1'b0, LAT);
`endif
        do_op(16'h0000, 16'hFD00, 16'h0000, 1'b0, 1'b0, LAT);
        do_op(16'h6400, 16'h0080, 16'h7FFF, 1'b1, 1'b0, LAT);
        do_op(16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0, LAT);
        do_op(16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0, LAT);
        do_op(16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1);
        do_op(16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b1, 1);
        do_op(16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1);

        // Handshake: valid_in held high with junk operands while busy.
        n = 0;
        while (!ready_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("hs_ready_start", 32'(ready_out), 32'd1);
        valid_in = 1'b1;
        dividend = 16'h0300;
        divisor  = 16'h0200;
        acc1     = cyc + 1;
        sb.push_back('{q: 16'h0180, ovf: 1'b0, dz: 1'b0, acc: acc1, lat: LAT});
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("hs_busy_ready", 32'(ready_out), 32'd0);
            dividend = 16'h7F00 + 16'(i);
            divisor  = 16'h0001;
        end
        @(negedge clk);
        check("hs_ready_after", 32'(ready_out), 32'd1);
        dividend = 16'hFF00;
        divisor  = 16'h0400;
        sb.push_back('{q: 16'hFFC0, ovf: 1'b0, dz: 1'b0, acc: cyc + 1, lat: LAT});
        check("hs_spacing", 32'(cyc + 1 - acc1), 32'(LAT + 1));
        @(negedge clk);
        valid_in = 1'b0;

        // Mid-operation reset: the aborted op must never produce valid_out.
        n = 0;
        while (!ready_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        valid_in = 1'b1;
        dividend = 16'h6400;
        divisor  = 16'h0080;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (9) @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(ready_out), 32'd1);
        check("abort_valid", 32'(valid_out), 32'd0);
        check("abort_quo", 32'(quo), 32'd0);
        rst_in = 1'b0;
        @(negedge clk);
        do_op(16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, LAT);

        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        repeat (40) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
